ext_pipe: RTL and testbench
===========================

// Module: ext_pipe
// PURPOSE
//   Parametrised, pipelined extension unit for the MIPS datapath. Handles immediate
//   extension (zero, sign, lui) and load-data extension (lb/lbu/lh/lhu by byte offset).
//   Sits between D->E for immediates and M->W for load data.
//   Uses a valid/ready elastic pipeline with flush, so it can stall with the core.
// PARAMETERS
//   DATA_W  32  output/word width; must be >= 32. Load modes select from word[31:0].
//   IMM_W   16  immediate width; must be <= DATA_W.
//   STAGES  1   register stages, 1..3. Latency = STAGES cycles when there is no backpressure.
// PORTS
//   clk        in   1        clock; all state updates on the rising edge
//   reset      in   1        asynchronous, active-high; clears all stages
//   flush      in   1        synchronous; drops every in-flight entry
//   in_valid   in   1        input entry present
//   in_ready   out  1        input accepted when in_valid && in_ready
//   in_mode    in   3        0 ZERO, 1 SIGN, 2 LUI, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 reserved
//   in_imm     in   IMM_W    immediate, used by modes 0-2
//   in_word    in   DATA_W   loaded word, used by modes 3-6
//   in_off     in   2        byte offset (addr[1:0]), used by modes 3-6
//   out_valid  out  1        result present
//   out_ready  in   1        result consumed when out_valid && out_ready
//   out_data   out  DATA_W   extended result
//   out_err    out  1        misalignment/reserved-mode flag (EXT_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//   Reset: all stage valid bits = 0, out_valid = 0, out_data = 0, out_err = 0.
//     in_ready = 1 one cycle after reset deasserts.
//   Arithmetic is computed combinationally before stage 1; later stages only carry data.
//     ZERO: {(DATA_W-IMM_W) x 0, imm}
//     SIGN: {(DATA_W-IMM_W) x imm[IMM_W-1], imm}
//     LUI:  imm in bits [DATA_W-1 -: IMM_W], zeros below
//     LB/LBU: b = word[8*off +: 8]; sign- or zero-extended to DATA_W
//     LH/LHU: h = word[16*off[1] +: 16]; off[0] ignored; sign- or zero-extended
//     mode 7: out_data = 0
//   Elastic pipeline: stage k loads when it is empty or stage k+1 (or the consumer)
//     takes its entry in the same cycle. in_ready = stage-1 load condition.
//   Throughput is 1 entry/cycle. No entry is dropped or duplicated under backpressure.
//   out_data and out_err are held stable while out_valid && !out_ready.
//   flush: at the clock edge, all valid bits are cleared. in_ready = 0 in the flush cycle,
//     so an input presented with flush is not accepted. Flush beats out_ready.
//   reset mid-operation: all entries are lost immediately (async). Nothing is emitted
//     until a new input is accepted.
//   Stage data registers are updated only on load (no update while a stage holds an
//     entry under stall).
// CONFIGURATION
//   EXT_ALIGN_CHECK_EN defined:
//     out_err = 1 for LH/LHU with off[0] = 1, and for mode 7.
//     out_err travels with its entry. out_data is still computed as above.
//   Not defined:
//     out_err is constant 0 and there is no check logic.
// STRUCTURE
//   Package ext_pkg: ext_mode_e enum (3-bit, encodings above) and EXT_MODE_W = 3.
//   Sub-module ext_core: purely combinational mode/offset -> DATA_W result (+ err).
//     ext_pipe instantiates ext_core followed by a generate loop of STAGES valid/data registers.
// TESTING (DATA_W=32, IMM_W=16 unless noted)
//   SIGN imm 16'h8001 -> 32'hFFFF8001; ZERO imm 16'h8001 -> 32'h00008001;
//     LUI 16'h1234 -> 32'h12340000; each appears STAGES cycles after acceptance.
//   word 32'h80FF7F01: LB off 2 -> 32'hFFFFFFFF; LBU off 3 -> 32'h00000080;
//     LH off 2 -> 32'hFFFF80FF; LHU off 0 -> 32'h00007F01.
//   STAGES=3, 5 back-to-back inputs, out_ready low for cycles 4-6 -> in_ready drops
//     when the pipeline is full; all 5 results arrive in order, none lost or duplicated.
//   flush while 2 entries are in flight and in_valid=1 -> next cycle out_valid=0;
//     the flushed-cycle input is never output.
//   reset asserted asynchronously mid-stream -> out_valid=0 and out_data=0 before the next edge.
//   With EXT_ALIGN_CHECK_EN: LH off 1 -> out_err=1; mode 7 -> out_data=0, out_err=1;
//     LB off 1 -> out_err=0.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the ext_pipe immediate/load-data extension unit.
package ext_pkg;

    localparam int EXT_MODE_W = 3;

    typedef enum logic [EXT_MODE_W-1:0] {
        EXT_ZERO = 3'd0,
        EXT_SIGN = 3'd1,
        EXT_LUI  = 3'd2,
        EXT_LB   = 3'd3,
        EXT_LBU  = 3'd4,
        EXT_LH   = 3'd5,
        EXT_LHU  = 3'd6,
        EXT_RSVD = 3'd7
    } ext_mode_e;

endpackage

// File: rtl/ext_core.sv
// Combinational extension datapath: mode/offset select and zero/sign/lui extend.
// Alignment/reserved-mode flag only generated when EXT_ALIGN_CHECK_EN is defined.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [EXT_MODE_W-1:0] mode_i,
    input  logic [IMM_W-1:0]      imm_i,
    input  logic [DATA_W-1:0]     word_i,
    input  logic [1:0]            off_i,
    output logic [DATA_W-1:0]     res_o,
    output logic                  err_o
);

    ext_mode_e   mode;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mode     = ext_mode_e'(mode_i);
    assign byte_sel = word_i[{off_i, 3'b000} +: 8];
    // off_i[0] is deliberately ignored for halfword selection
    assign half_sel = word_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        res_o = '0;
        case (mode)
            EXT_ZERO: res_o = DATA_W'(imm_i);
            EXT_SIGN: res_o = DATA_W'($signed(imm_i));
            EXT_LUI:  res_o[DATA_W-1 -: IMM_W] = imm_i;
            EXT_LB:   res_o = DATA_W'($signed(byte_sel));
            EXT_LBU:  res_o = DATA_W'(byte_sel);
            EXT_LH:   res_o = DATA_W'($signed(half_sel));
            EXT_LHU:  res_o = DATA_W'(half_sel);
            default:  res_o = '0;
        endcase
    end

`ifdef EXT_ALIGN_CHECK_EN
    assign err_o = (((mode == EXT_LH) || (mode == EXT_LHU)) && off_i[0])
                 || (mode == EXT_RSVD);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/ext_pipe.sv
// Elastic valid/ready extension pipeline (STAGES registers after ext_core) with flush.
// out_err carries the alignment flag only when EXT_ALIGN_CHECK_EN is defined.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXT_MODE_W-1:0] in_mode,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [DATA_W-1:0]     in_word,
    input  logic [1:0]            in_off,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err
);

    logic [DATA_W-1:0] core_res;
    logic              core_err;
    logic [STAGES-1:0] vld_all;
    logic [STAGES-1:0] ld;
    logic              bub;
    logic              init_q;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .mode_i (in_mode),
        .imm_i  (in_imm),
        .word_i (in_word),
        .off_i  (in_off),
        .res_o  (core_res),
        .err_o  (core_err)
    );

    // Unrolled form of "load when empty or downstream loads": stage k may load
    // iff the consumer is ready or any stage from k onward holds a bubble.
    always_comb begin
        ld  = '0;
        bub = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            bub = out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                bub = bub | ~vld_all[j];
            end
            ld[k] = bub;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) init_q <= 1'b0;
        else       init_q <= 1'b1;
    end

    assign in_ready = init_q & ~flush & ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              vld_d;
        logic [DATA_W-1:0] dat_d;
        logic              err_d;
        logic              vld_q;
        logic [DATA_W-1:0] dat_q;
        logic              err_q;

        if (k == 0) begin : g_head
            assign vld_d = in_valid & in_ready;
            assign dat_d = core_res;
            assign err_d = core_err;
        end else begin : g_body
            assign vld_d = g_stage[k-1].vld_q;
            assign dat_d = g_stage[k-1].dat_q;
            assign err_d = g_stage[k-1].err_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= 1'b0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (ld[k]) begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dat_q <= '0;
            end else if (!flush && ld[k] && vld_d) begin
                dat_q <= dat_d;
            end
        end

`ifdef EXT_ALIGN_CHECK_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                err_q <= 1'b0;
            end else if (!flush && ld[k] && vld_d) begin
                err_q <= err_d;
            end
        end
`else
        assign err_q = err_d;
`endif

        assign vld_all[k] = vld_q;
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_data  = g_stage[STAGES-1].dat_q;

`ifdef EXT_ALIGN_CHECK_EN
    assign out_err = g_stage[STAGES-1].err_q;
`else
    assign out_err = core_err;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Directed + random scoreboard bench for ext_pipe (STAGES=3); honours EXT_ALIGN_CHECK_EN.
module tb_ext_pipe;
    import ext_pkg::*;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int ST = 3;
`ifdef EXT_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]    in_mode;
    logic [IW-1:0] in_imm;
    logic [DW-1:0] in_word, out_data;
    logic [1:0]    in_off;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(DW), .IMM_W(IW), .STAGES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_word   (in_word),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0, n_bad = 0, cyc_n = 0, n_out = 0;
    bit          lat_chk = 1'b0, prev_stall = 1'b0, acc_last = 1'b0, saw_nr = 1'b0;
    logic [31:0] prev_d = '0, pend_d = '0;
    logic        prev_e = 1'b0, pend_e = 1'b0;

    function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] imm,
                                          input logic [31:0] w, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(off)));
        h = off[1] ? w[31:16] : w[15:0];
        case (m)
            EXT_ZERO: return {16'h0000, imm};
            EXT_SIGN: return {{16{imm[15]}}, imm};
            EXT_LUI:  return {imm, 16'h0000};
            EXT_LB:   return {{24{b[7]}}, b};
            EXT_LBU:  return {24'h000000, b};
            EXT_LH:   return {{16{h[15]}}, h};
            EXT_LHU:  return {16'h0000, h};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic errm(input logic [2:0] m, input logic [1:0] off);
        logic f;
        f = ((m == EXT_LH || m == EXT_LHU) && off[0]) || (m == EXT_RSVD);
        return f & ALIGN_EN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle (inputs settled, before the rising edge), then advance one cycle.
    task automatic cyc();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, prev_d);
            chk("hold_err", 32'(out_err), 32'(prev_e));
        end
        acc_last = in_valid && in_ready;
        if (in_valid && !in_ready) saw_nr = 1'b1;
        if (acc_last) sb.push_back('{d: pend_d, e: pend_e, acc: cyc_n});
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data", out_data, e.d);
                chk("err", 32'(out_err), 32'(e.e));
                if (lat_chk) chk("latency", cyc_n - e.acc, 32'(ST));
            end
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_d     = out_data;
        prev_e     = out_err;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] m, input logic [15:0] imm, input logic [31:0] w,
                         input logic [1:0] off, input logic [31:0] exp_d);
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_word  = w;
        in_off   = off;
        pend_d   = exp_d;
        pend_e   = errm(m, off);
    endtask

    task automatic drive_rand();
        logic [2:0]  m;
        logic [15:0] imm;
        logic [31:0] w;
        logic [1:0]  off;
        m   = 3'($urandom_range(0, 7));
        imm = 16'($urandom);
        w   = $urandom;
        off = 2'($urandom_range(0, 3));
        drive(m, imm, w, off, model(m, imm, w, off));
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int unsigned sent, t, outs0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mode = '0; in_imm = '0; in_word = '0; in_off = '0;

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Immediates and loads, back-to-back, latency checked
        lat_chk = 1'b1;
        drive(EXT_SIGN, 16'h8001, '0, 2'd0, 32'hFFFF8001); cyc();
        drive(EXT_ZERO, 16'h8001, '0, 2'd0, 32'h00008001); cyc();
        drive(EXT_LUI,  16'h1234, '0, 2'd0, 32'h12340000); cyc();
        drive(EXT_LB,   16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF); cyc();
        drive(EXT_LBU,  16'h0, 32'h80FF7F01, 2'd3, 32'h00000080); cyc();
        drive(EXT_LH,   16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF); cyc();
        drive(EXT_LHU,  16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01); cyc();
        // Alignment / reserved cases (data still computed; err per build)
        drive(EXT_LH,   16'h0, 32'h80FF7F01, 2'd1, 32'h00007F01); cyc();
        drive(EXT_RSVD, 16'hFFFF, 32'hFFFFFFFF, 2'd3, 32'h00000000); cyc();
        drive(EXT_LB,   16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F); cyc();
        drain(20);

        // Backpressure: 5 back-to-back entries, consumer stalls cycles 4-6
        lat_chk = 1'b0; saw_nr = 1'b0; sent = 0; outs0 = n_out; t = 0;
        while ((sent < 5 || sb.size() != 0) && t < 40) begin
            out_ready = !(t >= 4 && t <= 6);
            if (sent < 5) drive_rand(); else in_valid = 1'b0;
            cyc();
            if (acc_last) sent++;
            t++;
        end
        chk("bp_ready_dropped", 32'(saw_nr), 32'd1);
        chk("bp_left", 32'(sb.size()), 32'd0);
        chk("bp_count", n_out - outs0, 32'd5);
        sb.delete();

        // Flush with two entries in flight and an input presented
        out_ready = 1'b1;
        drive_rand(); cyc();
        drive_rand(); cyc();
        flush = 1'b1;
        drive_rand();
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (6) cyc();

        // Random traffic with random backpressure
        sent = 0; t = 0;
        in_valid = 1'b0;
        while (sent < 40 && t < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc_last) begin
                if ($urandom_range(0, 3) != 0) drive_rand(); else in_valid = 1'b0;
            end
            cyc();
            if (acc_last) sent++;
            t++;
        end
        chk("rand_sent", sent, 32'd40);
        drain(40);

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        repeat (3) begin drive_rand(); cyc(); end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 10) begin cyc(); t++; end
        chk("arst_precond", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_err", 32'(out_err), 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) cyc();
        chk("arst_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
